// File: rtl/zap_predecode_pkg.sv
// Shared definitions for the LDM/STM predecode sequencer.
// Contents: architectural constants, the hidden temporary register index,
// extension bit positions, data-processing opcodes, the sequencer state
// encoding, the latched block-transfer context and the expandability test.
package zap_predecode_pkg;

    localparam int ARCH_REGS = 32;
    localparam int INSTR_W   = 36;

    // T0 sits in the upper half of the register file.  Its low four bits go
    // into the ARM register field and the matching EXT_*_HI bit supplies bit 4.
    localparam logic [4:0] T0_IDX = 5'(ARCH_REGS / 2);

    localparam int EXT_RD_HI = 35;
    localparam int EXT_RN_HI = 34;

    localparam logic [3:0] OPC_MOV = 4'b1101;
    localparam logic [3:0] OPC_ADD = 4'b0100;
    localparam logic [3:0] OPC_SUB = 4'b0010;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_WB   = 2'd2
    } seq_state_t;

    // Fields of the block transfer being expanded.  w_eff already folds in
    // the rule that an LDM that loads its own base skips writeback.
    typedef struct packed {
        logic [3:0] cond;
        logic       p;
        logic       u;
        logic       l;
        logic       w_eff;
        logic [3:0] rn;
    } ldm_ctx_t;

    function automatic logic is_expandable(input logic valid, input logic [3:0] cond,
                                           input logic [2:0] op_class, input logic s_bit,
                                           input logic [15:0] reg_list);
        return valid && (op_class == 3'b100) && (cond != COND_NV) && !s_bit
               && (reg_list != 16'd0);
    endfunction

endpackage

// File: rtl/zap_ldmstm_sequencer_if.sv
// Fetch-side / decode-side bundle of the LDM/STM sequencer.
// i_*: instruction from fetch plus pipeline flush/stall controls.
// o_*: registered micro-op to decode, fetch hold and busy status.
// slave modport is the sequencer's view, master the upstream/driver view.
interface zap_ldmstm_sequencer_if;
    import zap_predecode_pkg::*;

    logic [INSTR_W-1:0] i_instruction;
    logic               i_instruction_valid;
    logic               i_clear_from_writeback;
    logic               i_data_stall;
    logic               i_clear_from_alu;
    logic               i_stall_from_shifter;
    logic               i_stall_from_issue;
    logic               i_stall_from_decode;
    logic [INSTR_W-1:0] o_instruction;
    logic               o_instruction_valid;
    logic               o_stall_from_sequencer;
    logic               o_busy;

    modport slave (
        input  i_instruction, i_instruction_valid, i_clear_from_writeback, i_data_stall,
               i_clear_from_alu, i_stall_from_shifter, i_stall_from_issue, i_stall_from_decode,
        output o_instruction, o_instruction_valid, o_stall_from_sequencer, o_busy
    );

    modport master (
        output i_instruction, i_instruction_valid, i_clear_from_writeback, i_data_stall,
               i_clear_from_alu, i_stall_from_shifter, i_stall_from_issue, i_stall_from_decode,
        input  o_instruction, o_instruction_valid, o_stall_from_sequencer, o_busy
    );

endinterface

// File: rtl/zap_lowest_set_bit.sv
// Lowest-set-bit finder for a 16-entry register list (combinational).
// Ports: list (16-bit mask in), index (position of lowest set bit),
//        zero (list is empty; index is 0 in that case).
module zap_lowest_set_bit (
    input  logic [15:0] list,
    output logic [3:0]  index,
    output logic        zero
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (list[i]) begin
                index = 4'(i);
            end
        end
    end

    assign zero = (list == 16'd0);

endmodule

// File: rtl/zap_ldmstm_sequencer.sv
// LDM/STM predecode sequencer in front of the decode stage.
// Block transfers become MOV T0,Rn + one LDR/STR per listed register
// (ascending, T0-relative) + optional ADD/SUB base writeback; everything else
// passes through with one cycle of latency.
// Ports: i_clk, i_reset (async, active high), bus (slave modport of
//        zap_ldmstm_sequencer_if: fetch input, flush/stall controls,
//        registered micro-op output, fetch hold, busy).
module zap_ldmstm_sequencer
    import zap_predecode_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_reset,
    zap_ldmstm_sequencer_if.slave   bus
);

    seq_state_t         state_reg, state_next;
    logic [INSTR_W-1:0] instr_reg, instr_next;
    logic               valid_reg, valid_next;
    logic [15:0]        list_reg, list_next;   // registers still to transfer
    logic [4:0]         count_reg, count_next; // N, 1..16
    logic [3:0]         ord_reg, ord_next;     // ordinal k of the next transfer
    ldm_ctx_t           ctx_reg, ctx_next;

    logic [INSTR_W-1:0] in_word;
    logic [15:0]        in_list;
    logic [4:0]         in_count;
    logic               expandable;
    ldm_ctx_t           in_ctx;

    assign in_word    = bus.i_instruction;
    assign in_list    = in_word[15:0];
    assign expandable = is_expandable(bus.i_instruction_valid, in_word[31:28],
                                      in_word[27:25], in_word[22], in_list);

    always_comb begin
        in_count = 5'd0;
        for (int i = 0; i < 16; i++) begin
            in_count = in_count + 5'(in_list[i]);
        end
    end

    always_comb begin
        in_ctx.cond  = in_word[31:28];
        in_ctx.p     = in_word[24];
        in_ctx.u     = in_word[23];
        in_ctx.l     = in_word[20];
        in_ctx.rn    = in_word[19:16];
        in_ctx.w_eff = in_word[21] & ~(in_word[20] & in_list[in_word[19:16]]);
    end

    logic [3:0]  lsb_idx;
    logic        lsb_zero;
    logic [15:0] rest_list;
    logic        last_xfer;

    zap_lowest_set_bit u_lsb (
        .list  (list_reg),
        .index (lsb_idx),
        .zero  (lsb_zero)
    );

    assign rest_list = list_reg & ~(16'd1 << lsb_idx);
    assign last_xfer = (rest_list == 16'd0);

    // Signed byte offset from T0 for the k-th transfer of an N-register block.
    logic signed [8:0] k4, n4, offset;
    logic [8:0]        offset_mag;

    always_comb begin
        k4 = $signed({3'b000, ord_reg, 2'b00});
        n4 = $signed({2'b00, count_reg, 2'b00});
        case ({ctx_reg.p, ctx_reg.u})
            2'b01:   offset = k4;
            2'b11:   offset = k4 + 9'sd4;
            2'b00:   offset = k4 - n4 + 9'sd4;
            default: offset = k4 - n4;
        endcase
        offset_mag = offset[8] ? 9'(-offset) : 9'(offset);
    end

    logic [INSTR_W-1:0] mov_uop, xfer_uop, wb_uop;

    always_comb begin
        mov_uop = {4'b0000, in_word[31:28], 3'b000, OPC_MOV, 1'b0, 4'b0000,
                   T0_IDX[3:0], 8'h00, in_word[19:16]};
        mov_uop[EXT_RD_HI] = 1'b1;

        xfer_uop = {4'b0000, ctx_reg.cond, 3'b010, 1'b1, ~offset[8], 1'b0, 1'b0,
                    ctx_reg.l, T0_IDX[3:0], lsb_idx, 3'b000, offset_mag};
        xfer_uop[EXT_RN_HI] = 1'b1;

        wb_uop = {4'b0000, ctx_reg.cond, 3'b001, (ctx_reg.u ? OPC_ADD : OPC_SUB), 1'b0,
                  T0_IDX[3:0], ctx_reg.rn, 4'b0000, 1'b0, count_reg, 2'b00};
        wb_uop[EXT_RN_HI] = 1'b1;
    end

    logic flush, advance;
    assign flush   = bus.i_clear_from_writeback | (~bus.i_data_stall & bus.i_clear_from_alu);
    assign advance = ~bus.i_data_stall & ~bus.i_stall_from_shifter
                   & ~bus.i_stall_from_issue & ~bus.i_stall_from_decode;

    always_comb begin
        state_next = state_reg;
        instr_next = instr_reg;
        valid_next = valid_reg;
        list_next  = list_reg;
        count_next = count_reg;
        ord_next   = ord_reg;
        ctx_next   = ctx_reg;

        if (flush) begin
            state_next = ST_IDLE;
            valid_next = 1'b0;
            list_next  = 16'd0;
        end else if (advance) begin
            case (state_reg)
                ST_IDLE: begin
                    if (expandable) begin
                        instr_next = mov_uop;
                        valid_next = 1'b1;
                        ctx_next   = in_ctx;
                        list_next  = in_list;
                        count_next = in_count;
                        ord_next   = 4'd0;
                        state_next = ST_XFER;
                    end else begin
                        instr_next = in_word;
                        valid_next = bus.i_instruction_valid;
                    end
                end
                ST_XFER: begin
                    instr_next = xfer_uop;
                    valid_next = ~lsb_zero;
                    list_next  = rest_list;
                    ord_next   = ord_reg + 4'd1;
                    if (last_xfer) begin
                        state_next = ctx_reg.w_eff ? ST_WB : ST_IDLE;
                    end
                end
                ST_WB: begin
                    instr_next = wb_uop;
                    valid_next = 1'b1;
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
            instr_reg <= '0;
            valid_reg <= 1'b0;
            list_reg  <= '0;
            count_reg <= '0;
            ord_reg   <= '0;
            ctx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            instr_reg <= instr_next;
            valid_reg <= valid_next;
            list_reg  <= list_next;
            count_reg <= count_next;
            ord_reg   <= ord_next;
            ctx_reg   <= ctx_next;
        end
    end

    // Fetch is released in the cycle that emits the final micro-op so the
    // next instruction arrives just as the sequencer returns to IDLE.
    logic stall;
    always_comb begin
        case (state_reg)
            ST_IDLE: stall = expandable;
            ST_XFER: stall = ~(last_xfer & ~ctx_reg.w_eff);
            default: stall = 1'b0;
        endcase
    end

    assign bus.o_instruction          = instr_reg;
    assign bus.o_instruction_valid    = valid_reg;
    assign bus.o_stall_from_sequencer = stall;
    assign bus.o_busy                 = (state_reg != ST_IDLE);

endmodule
